// File: rtl/serial_adder_sequencer_if.sv
// ---------------------------------------------------------------------------
// serial_adder_sequencer_if
//   Request/response bundle between a requesting datapath (master) and the
//   nibble-serial adder (slave).
//
//   start  : master -> slave, request strobe. It is sampled only when the
//            adder is ready (idle or done).
//   c_in   : master -> slave, carry into nibble 0, captured with start.
//   x, y   : master -> slave, WIDTH-bit operands, captured with start.
//   busy   : slave -> master, high while nibbles are being summed.
//   done   : slave -> master, one-cycle completion pulse.
//   s      : slave -> master, registered WIDTH-bit sum.
//   c_out  : slave -> master, registered carry out of the top nibble.
// ---------------------------------------------------------------------------
interface serial_adder_sequencer_if #(
  parameter int WIDTH = 16
) ();
  logic             start;
  logic             c_in;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             c_out;

  modport master (
    output start, c_in, x, y,
    input  busy, done, s, c_out
  );

  modport slave (
    input  start, c_in, x, y,
    output busy, done, s, c_out
  );
endinterface

// File: rtl/serial_adder_sequencer.sv
// ---------------------------------------------------------------------------
// serial_adder_sequencer
//   Wide unsigned adder that reuses one 4-bit ripple-carry slice. It sums
//   one nibble per clock, least-significant nibble first. The carry between
//   nibbles is held in a register, so the combinational path is a single
//   4-bit ripple. The final result is {c_out, s} = x + y + c_in.
//
//   Ports:
//     clk    : single clock, rising-edge
//     reset  : synchronous, active-high
//     bus    : serial_adder_sequencer_if.slave (start/c_in/x/y in,
//              busy/done/s/c_out out). The interface WIDTH must match the
//              WIDTH of this module.
//
//   Timing: the request is accepted on edge E0. Nibbles are summed on edges
//   E1..E(WIDTH/4). done is high in the cycle after E(WIDTH/4).
// ---------------------------------------------------------------------------
module serial_adder_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  serial_adder_sequencer_if.slave  bus
);

  localparam int NIB   = WIDTH / 4;
  localparam int CNT_W = $clog2(NIB) + 1;

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_check
    $error("serial_adder_sequencer: WIDTH must be a multiple of 4 and >= 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   xa;
  logic [WIDTH-1:0]   ya;
  logic [WIDTH-1:0]   acc;
  logic               cy;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   s_q;
  logic               c_out_q;
  logic               busy_q;
  logic               done_q;

  logic [3:0]         nib_sum;
  logic               nib_cout;
  logic [WIDTH-1:0]   acc_next;
  logic               last_nib;

  // One complete adder: returns {carry, sum}.
  function automatic logic [1:0] full_add(input logic a, input logic b,
                                          input logic ci);
    full_add = {(a & b) | (ci & (a ^ b)), a ^ b ^ ci};
  endfunction

  // Four complete adders chained as a ripple: returns {carry, sum[3:0]}.
  function automatic logic [4:0] ripple4(input logic [3:0] a,
                                         input logic [3:0] b,
                                         input logic       ci);
    logic       c;
    logic [1:0] r;
    logic [3:0] sm;
    c  = ci;
    sm = '0;
    for (int i = 0; i < 4; i++) begin
      r     = full_add(a[i], b[i], c);
      sm[i] = r[0];
      c     = r[1];
    end
    ripple4 = {c, sm};
  endfunction

  // The shared slice always works on the low nibbles. Its carry-in is the
  // inter-nibble carry register.
  always_comb begin
    {nib_cout, nib_sum} = ripple4(xa[3:0], ya[3:0], cy);
    // The new nibble enters at the top, so after NIB shifts the
    // least-significant nibble sits at [3:0]. Written with shifts so that
    // WIDTH=4 elaborates without a null slice.
    acc_next = (acc >> 4) | (WIDTH'(nib_sum) << (WIDTH - 4));
    last_nib = (cnt == CNT_W'(NIB - 1));
  end

  // Stage: request capture / nibble iteration / result publish
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      s_q     <= '0;
      c_out_q <= 1'b0;
      cy      <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            xa     <= bus.x;
            ya     <= bus.y;
            cy     <= bus.c_in;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          xa  <= xa >> 4;
          ya  <= ya >> 4;
          acc <= acc_next;
          cy  <= nib_cout;
          cnt <= cnt + 1'b1;
          // s and c_out are written only here, so the outputs never show
          // a partial sum.
          if (last_nib) begin
            s_q     <= acc_next;
            c_out_q <= nib_cout;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state   <= DONE;
          end
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.s     = s_q;
  assign bus.c_out = c_out_q;

endmodule

// File: doc/serial_adder_sequencer.md
# serial_adder_sequencer

Nibble-serial wide adder that reuses one 4-bit ripple-carry adder slice, built from our complete adders, to sum two WIDTH-bit operands. It adds one nibble per clock, least-significant first, and keeps the inter-nibble carry in a register. A start/busy/done handshake sequences the work. It sits between a requesting datapath and the shared 4-bit adder, trading latency for area on wide additions.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4 (elaboration error otherwise)
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when the block is ready (IDLE or DONE)
- c_in  input  1  carry into nibble 0; captured with start
- x  input  WIDTH  operand A; captured with start
- y  input  WIDTH  operand B; captured with start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse; s and c_out are valid from this cycle onward
- s  output  WIDTH  registered sum
- c_out  output  1  registered carry out of the top nibble

## Operation
- Internal state:
  - operand shift registers xa and ya (WIDTH each)
  - result shift register acc (WIDTH)
  - carry register cy
  - nibble counter cnt, width clog2(WIDTH/4)+1
- The single 4-bit adder instance has:
  - inputs xa[3:0] and ya[3:0]
  - carry-in driven by cy; must not be tied to a constant
- FSM states: IDLE, RUN, DONE.
- IDLE: if start=1, load xa←x, ya←y, cy←c_in, cnt←0, then go to RUN. Otherwise stay.
- RUN: each cycle:
  - shift xa and ya right by 4
  - acc←{adder_sum, acc[WIDTH-1:4]}
  - cy←adder_cout
  - cnt←cnt+1
- When cnt=WIDTH/4-1 in RUN, the same edge also:
  - loads s←{adder_sum, acc[WIDTH-1:4]}
  - loads c_out←adder_cout
  - moves to DONE
- DONE: done=1 for exactly one cycle.
  - If start=1 in DONE, the new request is accepted exactly as from IDLE and the next state is RUN.
  - Otherwise the next state is IDLE.
- start in RUN is ignored: no queuing, no effect on the current operation.
- s and c_out hold their last result until the next completion. They never show partial sums.
- Arithmetic is unsigned modulo 2^WIDTH, with the carry out reported on c_out. {c_out,s} = x + y + c_in.
- Reset values: state=IDLE, busy=0, done=0, s=0, c_out=0, cy=0, cnt=0, acc=0.
- Reset mid-RUN aborts the operation. s and c_out return to 0, and no done is produced.
- Reset wins over start on the same edge.

## Timing
- Start accept edge E0. RUN covers edges E1..E(WIDTH/4). done is high in the cycle following edge E(WIDTH/4).
- Latency from the accept edge to done is WIDTH/4 cycles; this is 4 cycles for WIDTH=16.
- busy is high in the cycles after E0 through E(WIDTH/4-1), i.e. exactly WIDTH/4 cycles. busy=0 while done=1.
- Back-to-back throughput: one result every WIDTH/4+1 cycles, with start held or re-asserted in DONE.
- Carry propagates only through cy between nibbles, so the combinational path is one 4-bit ripple.
- Outputs are registered. done, busy, s and c_out change only on clock edges.

## Test plan
- WIDTH=16, x=0x1234, y=0x4321, c_in=0, start pulse -> busy for 4 cycles, then done pulse with s=0x5555, c_out=0.
- x=0xFFFF, y=0x0001, c_in=0 -> s=0x0000, c_out=1; the carry must cross all four nibbles via cy.
- x=0xFFFF, y=0x0000, c_in=1 -> s=0x0000, c_out=1, which checks that c_in reaches nibble 0. Then x=0x0000, y=0x0000, c_in=1 -> s=0x0001, c_out=0.
- While busy with 0x00FF+0x0001, pulse start with x=0xAAAA, y=0x5555 -> ignored. Result s=0x0100, c_out=0, and only one done pulse.
- Assert reset on the 2nd RUN cycle of 0x8000+0x8000 -> next cycle busy=0, done=0, s=0, c_out=0. No done follows. A fresh start afterward yields the correct sum.
- Hold start=1 continuously with operands 0x0001+0x0001, then 0x7FFF+0x0001 presented in the DONE cycle -> done pulses 5 cycles apart, with s=0x0002 then s=0x8000, and c_out=0 both times.
